// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter
//
// Purpose
//   Owns the Common Data Bus of the Tomasulo core.
//   Every functional unit raises a level request together with its result
//   payload. Each cycle one requester is picked in round-robin order, and its
//   payload is registered onto the bus with the ON bit set.
//   A unit that has just been granted sits out the following cycle. This
//   cooldown protects units whose request only drops at the "taken" negedge,
//   so that a single result is never broadcast twice.
//
// Parameters
//   NUM_REQ   number of functional-unit requesters (index 0 = ALU), >= 2
//   PAY_W     payload width {FU tag, RS one-hot[2:0], data[31:0]}
//
// Ports
//   clk       in   core clock; all state updates on its rising edge
//   rst_n     in   asynchronous reset, active low
//   flush     in   pipeline flush; kills the broadcast, holds the RR pointer
//   req       in   per-unit CDB request, level, held until taken
//   payload   in   per-unit result; slice i = payload[i*PAY_W +: PAY_W]
//   cdb       out  {ON, payload}; ON is the MSB (`CDB_ON_FIELD)
//   grant     out  registered one-hot of the unit currently on the bus
//   busy_cnt  out  saturating count of cycles that carried a broadcast
// ============================================================================

`ifndef NUM_CDBBITS
`define NUM_CDBBITS 38
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD 37
`endif

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PAY_W   = `NUM_CDBBITS - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAY_W-1:0] payload,
    output logic [`NUM_CDBBITS-1:0]  cdb,
    output logic [NUM_REQ-1:0]       grant,
    output logic [15:0]              busy_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W:0]     sum;
    logic [NUM_REQ-1:0] cooldown;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               hit;
    logic [PAY_W-1:0]   sel_payload;

    // The cooldown mask is always the one-hot of the previous cycle's
    // winner. It is cleared on idle cycles, on flush and on reset, which
    // is exactly the behaviour of the registered grant. So grant is reused
    // as the mask and no second copy of that state is kept.
    assign cooldown = grant;

    // Round-robin search. Candidates are visited starting at ptr and
    // wrapping modulo NUM_REQ. The sum carries one spare bit, so the wrap
    // is also correct when NUM_REQ is not a power of two.
    always_comb begin
        eligible = req & ~cooldown;
        hit      = 1'b0;
        sel      = ptr;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!hit && eligible[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    // Winner-derived values: the pointer moves just past the winner, and
    // the winner's payload slice is muxed out for registering.
    always_comb begin
        if (int'(sel) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = sel + 1'b1;
        end
        sel_onehot  = NUM_REQ'(1) << sel;
        sel_payload = payload[sel*PAY_W +: PAY_W];
    end

    // Bus, grant, pointer and activity counter.
    // Flush has priority over any request and leaves the pointer untouched,
    // so fairness resumes from where it stopped. Idle cycles drive an
    // all-zero bus rather than holding the stale payload. This keeps the
    // bus contents unambiguous when the ON bit is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb      <= '0;
            grant    <= '0;
            ptr      <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            cdb   <= '0;
            grant <= '0;
        end else if (hit) begin
            cdb   <= {1'b1, sel_payload};
            grant <= sel_onehot;
            ptr   <= next_ptr;
            if (busy_cnt != 16'hFFFF) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
        end else begin
            cdb   <= '0;
            grant <= '0;
        end
    end

endmodule
